// File: rtl/dig_in_filter_app_pkg.sv
// Shared address map and constants for the digital-input filter block.
package dig_in_filter_app_pkg;

   localparam logic [7:0] READ_DIG_FILT_BASE = 8'h40;

   localparam int OFS_THRESH = 0;
   localparam int OFS_STATE  = 1;
   localparam int OFS_RISE   = 2;
   localparam int OFS_FALL   = 3;
   localparam int OFS_STRIDE = 3;

   function automatic int n_addr(input int nw);
      return 1 + OFS_STRIDE * nw;
   endfunction

endpackage

// File: rtl/dig_in_filter_app_chan.sv
// One debounce channel: two-flop synchroniser, stability counter and
// stable bit, with single-cycle rise/fall pulses on each accepted change.
module dig_in_filt_chan #(
   parameter int CNT_W = 8
) (
   input  logic             xclk,
   input  logic             reset,
   input  logic             i_pin_n,
   input  logic             i_clr_cnt,
   input  logic [CNT_W-1:0] i_thresh,
   output logic             o_st,
   output logic             o_rise,
   output logic             o_fall
);

   logic             r_sync1;
   logic             r_s;
   logic             r_st;
   logic [CNT_W-1:0] r_cnt;
   logic             w_accept;

   assign w_accept = !i_clr_cnt && (r_s != r_st) && (r_cnt == i_thresh);
   assign o_st     = r_st;
   assign o_rise   = w_accept && r_s;
   assign o_fall   = w_accept && !r_s;

   always_ff @(posedge xclk) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_s     <= 1'b0;
         r_st    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= ~i_pin_n;
         r_s     <= r_sync1;
         // A threshold load restarts every pending count.
         if (i_clr_cnt || (r_s == r_st)) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_st  <= r_s;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dig_in_filter_app.sv
// Digital-input front end: per-channel debounce, sticky W1C edge latches,
// threshold register and bus read mux.
module dig_in_filter_app
   import dig_in_filter_app_pkg::*;
#(
   parameter int         N_CH       = 16,
   parameter int         CNT_W      = 8,
   parameter int         DEF_THRESH = 3,
   parameter logic [7:0] BASE_ADDR  = READ_DIG_FILT_BASE
) (
   input  logic            xclk,
   input  logic            reset,
   input  logic            write_qualified,
   input  logic            read_qualified,
   input  logic [7:0]      ab,
   input  logic [15:0]     db_in,
   input  logic [N_CH-1:0] dig_in,
   output logic [15:0]     db_out_DIGF,
   output logic            data_from_DIGF_avail,
   output logic            edge_flag
);

   localparam int NW = N_CH / 16;

   logic [CNT_W-1:0] r_thresh;
   logic [N_CH-1:0]  r_rise;
   logic [N_CH-1:0]  r_fall;
   logic [N_CH-1:0]  w_st;
   logic [N_CH-1:0]  w_rise_p;
   logic [N_CH-1:0]  w_fall_p;
   logic [N_CH-1:0]  w_clr_rise;
   logic [N_CH-1:0]  w_clr_fall;
   logic [7:0]       w_ofs;
   logic             w_thr_wr;
   logic             w_hit;
   logic [15:0]      w_rdata;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      dig_in_filt_chan #(.CNT_W(CNT_W)) u_chan (
         .xclk     (xclk),
         .reset    (reset),
         .i_pin_n  (dig_in[i]),
         .i_clr_cnt(w_thr_wr),
         .i_thresh (r_thresh),
         .o_st     (w_st[i]),
         .o_rise   (w_rise_p[i]),
         .o_fall   (w_fall_p[i])
      );
   end

   always_comb begin
      w_ofs      = ab - BASE_ADDR;
      w_hit      = 1'b0;
      w_rdata    = 16'hFFFF;
      w_clr_rise = '0;
      w_clr_fall = '0;
      w_thr_wr   = write_qualified && (w_ofs == 8'(OFS_THRESH));
      if (w_ofs == 8'(OFS_THRESH)) begin
         w_hit   = 1'b1;
         w_rdata = 16'(r_thresh);
      end
      for (int k = 0; k < NW; k++) begin
         if (w_ofs == 8'(OFS_STATE + OFS_STRIDE * k)) begin
            w_hit   = 1'b1;
            w_rdata = w_st[16*k +: 16];
         end
         if (w_ofs == 8'(OFS_RISE + OFS_STRIDE * k)) begin
            w_hit   = 1'b1;
            w_rdata = r_rise[16*k +: 16];
            if (write_qualified) w_clr_rise[16*k +: 16] = db_in;
         end
         if (w_ofs == 8'(OFS_FALL + OFS_STRIDE * k)) begin
            w_hit   = 1'b1;
            w_rdata = r_fall[16*k +: 16];
            if (write_qualified) w_clr_fall[16*k +: 16] = db_in;
         end
      end
   end

   always_ff @(posedge xclk) begin
      if (!reset) begin
         r_thresh             <= CNT_W'(DEF_THRESH);
         r_rise               <= '0;
         r_fall               <= '0;
         db_out_DIGF          <= '0;
         data_from_DIGF_avail <= 1'b0;
      end else begin
         // New edges override a same-cycle clear of the same bit.
         r_rise <= (r_rise & ~w_clr_rise) | w_rise_p;
         r_fall <= (r_fall & ~w_clr_fall) | w_fall_p;
         if (w_thr_wr) r_thresh <= db_in[CNT_W-1:0];
         if (read_qualified) begin
            db_out_DIGF          <= w_hit ? w_rdata : 16'hFFFF;
            data_from_DIGF_avail <= w_hit;
         end
      end
   end

   assign edge_flag = |{r_rise, r_fall};

endmodule

// File: doc/dig_in_filter_app.md
# dig_in_filter_app

Parametrised digital-input front end on the FPGA address/data bus, superseding the fixed 16-bit two-sample debouncer. It synchronises N_CH active-low pins and debounces each with a programmable stability counter. It latches rising and falling edges in sticky, write-1-to-clear registers and raises an interrupt-style flag. It is read and configured by the DSP through the same qualified read/write strobes and 8-bit address bus as the other apps.

## Interface
- N_CH, 16, channel count; multiple of 16, 16..64; NW = N_CH/16 data words
- CNT_W, 8, debounce counter width
- DEF_THRESH, 3, threshold loaded at reset; must fit CNT_W bits
- BASE_ADDR, READ_DIG_FILT_BASE, first bus address of the block; block occupies 1+3·NW addresses
- xclk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- write_qualified  in  1  one-cycle write strobe, ab/db_in valid
- read_qualified  in  1  one-cycle read strobe, ab valid
- ab  in  8  address bus
- db_in  in  16  write data bus
- dig_in  in  N_CH  raw pins, active-low; bit i = channel i
- db_out_DIGF  out  16  read data
- data_from_DIGF_avail  out  1  high when db_out_DIGF holds a mapped read
- edge_flag  out  1  OR of all rise/fall latch bits

## Operation
- Address map, offset from BASE_ADDR, k = 0..NW-1:
  - +0: THRESH, RW, bits [CNT_W-1:0]; other bits read 0, ignore writes
  - +1+3k: STATE word k, RO, debounced level of channels 16k..16k+15 (1 = pin low)
  - +2+3k: RISE word k, R/W1C, sticky 0→1 transitions of STATE
  - +3+3k: FALL word k, R/W1C, sticky 1→0 transitions of STATE
- Per channel: two-flop synchroniser of ~dig_in[i] → s[i]; counter cnt[i], stable bit st[i].
  - s == st: cnt <= 0.
  - s != st and cnt < THRESH: cnt <= cnt+1.
  - s != st and cnt == THRESH: st <= s, cnt <= 0, set RISE (if s=1) or FALL (if s=0) bit.
  - A glitch shorter than THRESH+1 cycles never changes st.
- Writes to STATE or unmapped addresses are ignored.
- Write to THRESH clears every cnt to 0 in the same cycle as the load.
- Same-cycle W1C clear and new edge on the same bit: set wins.
- Counter saturates by construction (never exceeds THRESH); THRESH = 0 means accept after one mismatched synchronised sample.
- Read: on read_qualified with ab mapped, db_out_DIGF <= register value, avail <= 1. With ab unmapped, db_out_DIGF <= 16'hFFFF, avail <= 0. Without read_qualified, both hold.
- Reads have no side effects; latches clear only by write.

## Timing
- Reset (sync, reset=0 at a rising edge): db_out_DIGF = 0, data_from_DIGF_avail = 0, edge_flag = 0, st/cnt/RISE/FALL = 0, synchronisers = 0, THRESH = DEF_THRESH.
- Pin edge, held stable: s changes 2 clocks after pin sample; st, latch and edge_flag update THRESH+1 clocks later. Total = THRESH+3 clocks.
- Read latency: 1 clock (data valid the edge after read_qualified). Read returns state as of the strobe cycle.
- W1C takes effect the clock after write_qualified; edge_flag drops the same clock if no bits remain.
- Reset asserted mid-count discards pending transitions; no latch is set.

## Structure
- Address offsets (THRESH, STATE, RISE, FALL stride 3) and READ_DIG_FILT_BASE go in Address_Bus_Defs.v.
- Sub-module dig_in_filt_chan: synchroniser, counter, stable bit, rise/fall pulse outputs. Instantiate N_CH times via generate.
- Top handles the THRESH register, latch arrays, W1C, read mux and edge_flag.

## Test plan
- Reset, then read all addresses: THRESH = 3, STATE/RISE/FALL = 0, unmapped ab → 16'hFFFF with avail = 0.
- dig_in[5] driven low, held: STATE0 bit 5 = 1 exactly 6 clocks later; RISE0 = 16'h0020; edge_flag = 1.
- THRESH = 3; 3-cycle low pulse on dig_in[0] → no STATE/RISE change. 4-cycle pulse → RISE and FALL bit 0 both set.
- N_CH = 32: dig_in[17] low → STATE1 = 16'h0002; write 16'h0002 to RISE1 → reads 0, edge_flag = 0.
- W1C of RISE0 bit 3 in the same cycle a new rise sets it → bit stays 1.
- Write THRESH = 0 mid-count on a 2-cycle glitch → count restarts; a single-sample mismatch then is accepted (latency 3).
